// File: rtl/my_elastic_buf.sv
// Elastic buffer: circular-buffer FIFO with registered-only handshake outputs,
// synchronous flush, occupancy count and a registered almost-full flag.
module my_elastic_buf #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic [DW-1:0]              up_bus,
  input  logic                       up_val,
  output logic                       up_rdy,
  output logic [DW-1:0]              dn_bus,
  output logic                       dn_val,
  input  logic                       dn_rdy,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic          af;
  logic          push, pop;

  // handshake outputs come from registered occupancy only
  assign up_rdy        = (count != DEPTH_C);
  assign dn_val        = (count != '0);
  assign dn_bus        = mem[rptr];
  assign o_count       = count;
  assign o_almost_full = af;

  assign push = up_val && up_rdy;
  assign pop  = dn_val && dn_rdy;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      af    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count_nxt;
      af    <= (count_nxt >= AF_C);
    end
  end

  // storage is never reset; contents are don't-care while empty
  always_ff @(posedge i_clk) begin
    if (push && !i_reset && !i_flush) mem[wptr] <= up_bus;
  end
endmodule
